// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit constants, special-value helpers and result entry type
package posit_pkg;

  localparam int POSIT_N     = 8;
  localparam int POSIT_ES    = 3;
  localparam int POSIT_TAG_W = 4;
  localparam int POSIT_DEPTH = 4;

  function automatic logic [63:0] posit_nar(input int n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] posit_zero(input int n);
    return (64'd1 << n) - (64'd1 << n);
  endfunction

  typedef struct packed {
    logic [POSIT_N-1:0]     result;
    logic [POSIT_TAG_W-1:0] tag;
    logic                   nar;
    logic                   zero;
  } result_entry_t;

endpackage

// File: rtl/Posit_Multiplier.sv
// rtl/Posit_Multiplier.sv - combinational posit product with round-to-nearest-even
module Posit_Multiplier #(
  parameter int N  = 8,
  parameter int ES = 3
) (
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic [N-1:0] OUT
);

  localparam int FW = N - 1 - ES;
  localparam int PW = 2 * FW + 2;
  localparam int FB = PW - 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  // Scale is regime*2^ES + exponent; mantissa carries the hidden one.
  function automatic void decode(input logic [N-1:0] p, output int scale, output logic [FW:0] mant);
    logic [N-2:0] body;
    logic [N-2:0] rest;
    logic         rb;
    logic         stop;
    int           run;
    body = p[N-1] ? (N-1)'(-p) : p[N-2:0];
    rb   = body[N-2];
    run  = 0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == rb)) run = run + 1;
      else stop = 1'b1;
    end
    rest  = body << (run + 1);
    scale = (rb ? run - 1 : -run) * (1 << ES) + int'(rest[N-2 -: ES]);
    mant  = {1'b1, rest[FW-1:0]};
  endfunction

  function automatic logic [N-2:0] encode(input int scale, input logic [FB-1:0] frac);
    int           k;
    int           e;
    int           rl;
    int           sh;
    logic [63:0]  full;
    logic [N-2:0] kept;
    logic         rnd;
    logic         sticky;
    k = scale >>> ES;
    e = scale & ((1 << ES) - 1);
    if (k >= N - 2) return {(N-1){1'b1}};
    if (k < -(N - 2)) return (N-1)'(1);
    if (k >= 0) begin
      full = ((64'd1 << (k + 1)) - 64'd1) << 1;
      rl   = k + 2;
    end else begin
      full = 64'd1;
      rl   = 1 - k;
    end
    full   = (full << (ES + FB)) | (64'(e) << FB) | 64'(frac);
    sh     = rl + ES + FB - (N - 1);
    kept   = (N-1)'(full >> sh);
    rnd    = full[sh-1];
    sticky = |(full & ((64'd1 << (sh - 1)) - 64'd1));
    if (rnd && (sticky || kept[0])) kept = kept + (N-1)'(1);
    return kept;
  endfunction

  int           sc_a;
  int           sc_b;
  int           sc;
  logic [FW:0]  ma;
  logic [FW:0]  mb;
  logic [PW-1:0] prod;
  logic [FB-1:0] frac;
  logic [N-2:0] mag;

  always_comb begin
    sc_a = 0;
    sc_b = 0;
    ma   = '0;
    mb   = '0;
    decode(IN1, sc_a, ma);
    decode(IN2, sc_b, mb);
    prod = PW'(ma) * PW'(mb);
    if (prod[PW-1]) begin
      sc   = sc_a + sc_b + 1;
      frac = prod[PW-2:0];
    end else begin
      sc   = sc_a + sc_b;
      frac = {prod[PW-3:0], 1'b0};
    end
    mag = encode(sc, frac);
    OUT = '0;
    if ((IN1 == NAR) || (IN2 == NAR))       OUT = NAR;
    else if ((IN1 == '0) || (IN2 == '0))    OUT = '0;
    else if (IN1[N-1] ^ IN2[N-1])           OUT = -{1'b0, mag};
    else                                    OUT = {1'b0, mag};
  end

endmodule

// File: rtl/posit_result_fifo.sv
// rtl/posit_result_fifo.sv - result FIFO with explicit occupancy count and synchronous flush
module posit_result_fifo
  import posit_pkg::*;
#(
  parameter int DEPTH = POSIT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  result_entry_t            push_data_i,
  input  logic                     pop_i,
  output result_entry_t            head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  result_entry_t mem_q [DEPTH];

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  // Storage is reset so the head reads as all-zero while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_i) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/posit_mul_stream.sv
// rtl/posit_mul_stream.sv - streaming wrapper: operand register, posit multiplier, result FIFO
module posit_mul_stream
  import posit_pkg::*;
#(
  parameter int N     = POSIT_N,
  parameter int ES    = POSIT_ES,
  parameter int DEPTH = POSIT_DEPTH,
  parameter int TAG_W = POSIT_TAG_W
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_nar,
  output logic                   out_zero,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [N-1:0] NAR  = N'(posit_nar(N));
  localparam logic [N-1:0] ZERO = N'(posit_zero(N));

  logic             s1_valid_q;
  logic             s1_valid_d;
  logic [N-1:0]     s1_a_q;
  logic [N-1:0]     s1_b_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [N-1:0]     mul_out;
  logic             accept;
  logic             pop;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  result_entry_t    push_entry;
  result_entry_t    head;

  // Stage 1 always drains into the FIFO, so credit counts it as already occupying a slot.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(s1_valid_q);
  assign in_ready  = nReset & ~flush & (occupancy < (CW+1)'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign count     = CW'(occupancy);

  always_comb begin
    s1_valid_d = accept;
    if (flush) s1_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b;
        s1_tag_q <= in_tag;
      end
    end
  end

  Posit_Multiplier #(
    .N  (N),
    .ES (ES)
  ) u_mul (
    .IN1 (s1_a_q),
    .IN2 (s1_b_q),
    .OUT (mul_out)
  );

  always_comb begin
    push_entry        = '0;
    push_entry.result = mul_out;
    push_entry.tag    = s1_tag_q;
    push_entry.nar    = (s1_a_q == NAR) | (s1_b_q == NAR);
    push_entry.zero   = ~push_entry.nar & ((s1_a_q == ZERO) | (s1_b_q == ZERO));
  end

  posit_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (nReset),
    .flush_i     (flush),
    .push_i      (s1_valid_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign out_result = head.result;
  assign out_tag    = head.tag;
  assign out_nar    = head.nar;
  assign out_zero   = head.zero;

endmodule

// File: tb/tb_posit_mul_stream.sv
// tb/tb_posit_mul_stream.sv - scoreboard bench for posit_mul_stream (N=8, ES=3, DEPTH=4)
module tb_posit_mul_stream;

  localparam int N     = 8;
  localparam int ES    = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int EW    = N + TAG_W + 2;

  logic             clock;
  logic             nReset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_nar;
  logic             out_zero;
  logic [2:0]       count;

  posit_mul_stream #(.N(N), .ES(ES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_nar    (out_nar),
    .out_zero   (out_zero),
    .count      (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_pop    = 0;
  int cyc      = 0;
  logic [EW-1:0] cur_exp;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            pop_cyc[$];

  // Stimulus is applied at the falling edge; handshakes are sampled just before the rising edge.
  task automatic tick();
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      n_acc++;
    end
    if (out_valid && out_ready) begin
      obs_q.push_back({out_result, out_tag, out_nar, out_zero});
      pop_cyc.push_back(cyc);
      n_pop++;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic settle(input int budget, output bit timed_out);
    in_valid  = 1'b0;
    timed_out = 1'b0;
    while (n_pop < n_acc) begin
      if (budget == 0) begin
        timed_out = 1'b1;
        break;
      end
      budget--;
      tick();
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [N-1:0] res, input logic nar, input logic zero);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    cur_exp  = {res, tag, nar, zero};
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++;
    if ({out_result, out_tag, out_nar, out_zero} !== '0)
      $display("FAIL reset_outputs got %h want 0", {out_result, out_tag, out_nar, out_zero});
    else n_pass++;
    @(negedge clock);
    nReset = 1'b1;
  endtask

  task automatic test_single();
    bit to;
    logic [EW-1:0] e, o;
    out_ready = 1'b1;
    drive(8'h40, 8'h40, 4'd3, 8'h40, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", out_valid); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_latency got %b want 1", out_valid); else n_pass++;
    settle(10, to);
    n_checks++; if (to || exp_q.size() != obs_q.size()) $display("FAIL single_drain got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL single_result got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int base;
    logic [EW-1:0] e, o;
    out_ready = 1'b1;
    pop_cyc.delete();
    base = n_acc;
    drive(8'h40, 8'h44, 4'd1, 8'h44, 1'b0, 1'b0); tick();
    drive(8'hC0, 8'h40, 4'd2, 8'hC0, 1'b0, 1'b0); tick();
    drive(8'h44, 8'h44, 4'd4, 8'h48, 1'b0, 1'b0); tick();
    n_checks++; if (n_acc - base != 3) $display("FAIL b2b_accepts got %0d want 3", n_acc - base); else n_pass++;
    settle(10, to);
    n_checks++; if (to || exp_q.size() != obs_q.size()) $display("FAIL b2b_drain got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 1; i < pop_cyc.size(); i++) begin
      n_checks++;
      if (pop_cyc[i] - pop_cyc[i-1] != 1) $display("FAIL b2b_cadence got %0d want 1", pop_cyc[i] - pop_cyc[i-1]); else n_pass++;
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL b2b_result got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int base;
    logic [EW-1:0] e, o;
    out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 8; i++) begin
      drive(8'h40, 8'h40, TAG_W'(n_acc - base), 8'h40, 1'b0, 1'b0);
      tick();
    end
    #1;
    n_checks++; if (n_acc - base != 4) $display("FAIL bp_accepts got %0d want 4", n_acc - base); else n_pass++;
    n_checks++; if (count !== 3'd4) $display("FAIL bp_count got %0d want 4", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready); else n_pass++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_return got %b want 1", in_ready); else n_pass++;
    settle(10, to);
    n_checks++; if (to || exp_q.size() != obs_q.size()) $display("FAIL bp_drain got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL bp_result got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_specials();
    bit to;
    logic [EW-1:0] e, o;
    out_ready = 1'b1;
    drive(8'h80, 8'h40, 4'd6, 8'h80, 1'b1, 1'b0); tick();
    drive(8'h00, 8'hC0, 4'd7, 8'h00, 1'b0, 1'b1); tick();
    drive(8'h80, 8'h00, 4'd8, 8'h80, 1'b1, 1'b0); tick();
    drive(8'hC0, 8'hC0, 4'd9, 8'h40, 1'b0, 1'b0); tick();
    drive(8'h44, 8'hC0, 4'hA, 8'hBC, 1'b0, 1'b0); tick();
    drive(8'h38, 8'h48, 4'hB, 8'h40, 1'b0, 1'b0); tick();
    settle(12, to);
    n_checks++; if (to || exp_q.size() != obs_q.size()) $display("FAIL spec_drain got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL spec_result got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_flush();
    bit to;
    logic [EW-1:0] e, o;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'h44, 8'h40, TAG_W'(i), 8'h44, 1'b0, 1'b0);
      tick();
    end
    n_checks++; if (count !== 3'd4) $display("FAIL flush_pre_count got %0d want 4", count); else n_pass++;
    flush = 1'b1;
    drive(8'h40, 8'h40, 4'hF, 8'h40, 1'b0, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else n_pass++;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd0) $display("FAIL flush_count got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else n_pass++;
    exp_q.delete();
    obs_q.delete();
    n_acc = n_pop;
    out_ready = 1'b1;
    drive(8'h44, 8'h44, 4'd2, 8'h48, 1'b0, 1'b0);
    tick();
    settle(10, to);
    n_checks++; if (to || exp_q.size() != obs_q.size()) $display("FAIL flush_drain got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL flush_result got %h want %h", o, e); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bit to;
    logic [EW-1:0] e, o;
    out_ready = 1'b0;
    drive(8'h40, 8'h44, 4'd9, 8'h44, 1'b0, 1'b0); tick();
    drive(8'h44, 8'h44, 4'd9, 8'h48, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    #2;
    nReset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL arst_count got %0d want 0", count); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL arst_in_ready got %b want 0", in_ready); else n_pass++;
    n_checks++;
    if ({out_result, out_tag, out_nar, out_zero} !== '0)
      $display("FAIL arst_outputs got %h want 0", {out_result, out_tag, out_nar, out_zero});
    else n_pass++;
    exp_q.delete();
    obs_q.delete();
    n_acc = 0;
    n_pop = 0;
    out_ready = 1'b1;
    drive(8'h40, 8'h40, 4'd5, 8'h40, 1'b0, 1'b0);
    nReset = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd1) $display("FAIL arst_first_accept got %0d want 1", count); else n_pass++;
    settle(10, to);
    repeat (3) tick();
    n_checks++; if (to || n_pop != 1) $display("FAIL arst_pops got %0d want 1", n_pop); else n_pass++;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL arst_result got %h want %h", o, e); else n_pass++;
    end
  endtask

  initial begin
    nReset    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    cur_exp   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_specials();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
